// File: rtl/axiom_apb_mux_ctrl_pkg.sv
// Shared types and default widths for the axiom APB requester mux and its helpers.
package axiom_apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_STRB_W  = APB_DATA_W / 8;
    localparam int APB_OWNER_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One captured command; owner remembers which source gets the response.
    typedef struct packed {
        logic [APB_ADDR_W-1:0]  addr;
        logic                   write;
        logic [APB_DATA_W-1:0]  wdata;
        logic [APB_STRB_W-1:0]  wstrb;
        logic [2:0]             prot;
        logic [APB_OWNER_W-1:0] owner;
    } apb_cmd_t;

endpackage

// File: rtl/axiom_apb_mux_ctrl_if.sv
// Bundles the per-source command/response lanes and the shared APB requester wires.
interface axiom_apb_mux_ctrl_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr;
    logic [NUM_REQ-1:0]                req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata;
    logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb;
    logic [NUM_REQ*3-1:0]              req_prot;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [DATA_WIDTH-1:0]             rsp_rdata;
    logic                              rsp_slverr;
    logic                              psel;
    logic                              penable;
    logic                              pwrite;
    logic [ADDR_WIDTH-1:0]             paddr;
    logic [DATA_WIDTH-1:0]             pwdata;
    logic [DATA_WIDTH/8-1:0]           pwstrb;
    logic [2:0]                        pprot;
    logic [DATA_WIDTH-1:0]             prdata;
    logic                              pready;
    logic                              pslverr;

    // Controller side: drives APB and responses, consumes commands and completer replies.
    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output psel, penable, pwrite, paddr, pwdata, pwstrb, pprot
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  psel, penable, pwrite, paddr, pwdata, pwstrb, pprot
    );
endinterface

// File: rtl/axiom_apb_mux_ctrl_rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping around.
module axiom_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    int j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && !valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/axiom_apb_mux_ctrl.sv
// Shares one APB requester port among NUM_REQ command sources with round-robin arbitration.
module axiom_apb_mux_ctrl
    import axiom_apb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 16
) (
    input logic                  pclk,
    input logic                  presetn,
    axiom_apb_mux_ctrl_if.master bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    apb_cmd_t                cmd_q, cmd_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;

    logic                    arb_en;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic                    timeout_hit;
    logic                    done;

    // Gating with presetn keeps req_ready low for the whole reset window.
    axiom_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en && presetn),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_slverr_d = 1'b0;
        arb_en       = 1'b0;
        done         = 1'b0;
        // The abort fires on the ACCESS cycle that would push the wait count to TIMEOUT.
        timeout_hit  = (TIMEOUT != 0) && !bus.pready && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: arb_en = 1'b1;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (bus.pready || timeout_hit) begin
                    done         = 1'b1;
                    arb_en       = 1'b1;
                    cnt_d        = '0;
                    rsp_valid_d  = NUM_REQ'(1) << cmd_q.owner;
                    rsp_rdata_d  = (bus.pready && !cmd_q.write) ? bus.prdata : '0;
                    rsp_slverr_d = bus.pready ? bus.pslverr : 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_any) begin
            state_d     = SETUP;
            cnt_d       = '0;
            cmd_d.addr  = APB_ADDR_W'(bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
            cmd_d.write = bus.req_write[arb_idx];
            cmd_d.wdata = APB_DATA_W'(bus.req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH]);
            cmd_d.wstrb = bus.req_write[arb_idx]
                        ? APB_STRB_W'(bus.req_wstrb[int'(arb_idx)*STRB_W +: STRB_W]) : '0;
            cmd_d.prot  = bus.req_prot[int'(arb_idx)*3 +: 3];
            cmd_d.owner = APB_OWNER_W'(arb_idx);
            ptr_d       = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            cmd_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign bus.req_ready  = arb_gnt;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
    assign bus.psel       = (state_q != IDLE);
    assign bus.penable    = (state_q == ACCESS);
    assign bus.pwrite     = cmd_q.write;
    assign bus.paddr      = ADDR_WIDTH'(cmd_q.addr);
    assign bus.pwdata     = DATA_WIDTH'(cmd_q.wdata);
    assign bus.pwstrb     = STRB_W'(cmd_q.wstrb);
    assign bus.pprot      = cmd_q.prot;
endmodule

// File: tb/tb_axiom_apb_mux_ctrl.sv
// Directed bench for axiom_apb_mux_ctrl: single transfers, wait states, errors, timeout, reset, round-robin.
module tb_axiom_apb_mux_ctrl;
    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TO      = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic [3:0] expOneHot;

    axiom_apb_mux_ctrl_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axiom_apb_mux_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic nextCycle();
        @(negedge pclk);
    endtask

    task automatic applyStimulus(input int src, input logic valid, input logic [AW-1:0] addr,
                                 input logic write, input logic [DW-1:0] wdata,
                                 input logic [DW/8-1:0] wstrb, input logic [2:0] prot);
        bus.req_valid[src]               = valid;
        bus.req_addr[src*AW +: AW]       = addr;
        bus.req_write[src]               = write;
        bus.req_wdata[src*DW +: DW]      = wdata;
        bus.req_wstrb[src*DW/8 +: DW/8]  = wstrb;
        bus.req_prot[src*3 +: 3]         = prot;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.req_prot  = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset: outputs zero and req_ready gated even with a pending command.
        applyStimulus(0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0);
        #2;
        checkOutput("rst_req_ready", bus.req_ready, 4'b0000);
        checkOutput("rst_psel", bus.psel, 1'b0);
        checkOutput("rst_penable", bus.penable, 1'b0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        checkOutput("rst_paddr", bus.paddr, 32'h0);

        // Single write from src0, zero wait states.
        nextCycle();
        presetn    = 1'b1;
        bus.pready = 1'b1;
        #1;
        checkOutput("wr_req_ready", bus.req_ready, 4'b0001);
        checkOutput("wr_psel_idle", bus.psel, 1'b0);
        nextCycle();
        bus.req_valid[0] = 1'b0;
        #1;
        checkOutput("wr_setup_psel", bus.psel, 1'b1);
        checkOutput("wr_setup_penable", bus.penable, 1'b0);
        checkOutput("wr_paddr", bus.paddr, 32'h10);
        checkOutput("wr_pwdata", bus.pwdata, 32'hDEADBEEF);
        checkOutput("wr_pwstrb", bus.pwstrb, 4'hF);
        checkOutput("wr_pwrite", bus.pwrite, 1'b1);
        nextCycle();
        #1;
        checkOutput("wr_access_penable", bus.penable, 1'b1);
        checkOutput("wr_access_psel", bus.psel, 1'b1);
        checkOutput("wr_no_early_rsp", bus.rsp_valid, 4'b0000);
        nextCycle();
        #1;
        checkOutput("wr_rsp_valid", bus.rsp_valid, 4'b0001);
        checkOutput("wr_rsp_slverr", bus.rsp_slverr, 1'b0);
        checkOutput("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("wr_idle_psel", bus.psel, 1'b0);
        checkOutput("wr_idle_penable", bus.penable, 1'b0);
        nextCycle();
        #1;
        checkOutput("wr_rsp_pulse_end", bus.rsp_valid, 4'b0000);
        checkOutput("wr_pwdata_held", bus.pwdata, 32'hDEADBEEF);

        // Read from src2 with two wait states; pointer is now 1.
        nextCycle();
        bus.pready = 1'b0;
        applyStimulus(2, 1'b1, 32'h40, 1'b0, 32'h55555555, 4'hF, 3'd3);
        #1;
        checkOutput("rd_req_ready", bus.req_ready, 4'b0100);
        nextCycle();
        bus.req_valid[2] = 1'b0;
        #1;
        checkOutput("rd_setup_penable", bus.penable, 1'b0);
        checkOutput("rd_pwstrb_zero", bus.pwstrb, 4'h0);
        checkOutput("rd_pwrite", bus.pwrite, 1'b0);
        checkOutput("rd_paddr", bus.paddr, 32'h40);
        checkOutput("rd_pprot", bus.pprot, 3'd3);
        nextCycle();
        #1;
        checkOutput("rd_access1", bus.penable, 1'b1);
        nextCycle();
        #1;
        checkOutput("rd_access2", bus.penable, 1'b1);
        nextCycle();
        bus.pready = 1'b1;
        bus.prdata = 32'h12345678;
        #1;
        checkOutput("rd_access3", bus.penable, 1'b1);
        checkOutput("rd_no_early_rsp", bus.rsp_valid, 4'b0000);
        nextCycle();
        bus.prdata = 32'h0;
        #1;
        checkOutput("rd_rsp_valid", bus.rsp_valid, 4'b0100);
        checkOutput("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
        checkOutput("rd_rsp_slverr", bus.rsp_slverr, 1'b0);
        checkOutput("rd_idle_psel", bus.psel, 1'b0);

        // Slave error on a write from src1; pointer is now 3.
        nextCycle();
        bus.pslverr = 1'b1;
        applyStimulus(1, 1'b1, 32'h20, 1'b1, 32'hCAFE0001, 4'h3, 3'd0);
        #1;
        checkOutput("err_req_ready", bus.req_ready, 4'b0010);
        nextCycle();
        bus.req_valid[1] = 1'b0;
        nextCycle();
        #1;
        checkOutput("err_access", bus.penable, 1'b1);
        nextCycle();
        #1;
        checkOutput("err_rsp_valid", bus.rsp_valid, 4'b0010);
        checkOutput("err_rsp_slverr", bus.rsp_slverr, 1'b1);
        checkOutput("err_rsp_rdata", bus.rsp_rdata, 32'h0);

        // Timeout: src2 read never sees pready; pointer is now 2.
        nextCycle();
        bus.pslverr = 1'b0;
        bus.pready  = 1'b0;
        bus.prdata  = 32'hBAD0BAD0;
        applyStimulus(2, 1'b1, 32'h80, 1'b0, 32'h0, 4'h0, 3'd0);
        #1;
        checkOutput("to_req_ready", bus.req_ready, 4'b0100);
        nextCycle();
        bus.req_valid[2] = 1'b0;
        for (int i = 0; i < TO; i++) nextCycle();
        #1;
        checkOutput("to_last_access", bus.penable, 1'b1);
        checkOutput("to_no_early_rsp", bus.rsp_valid, 4'b0000);
        nextCycle();
        #1;
        checkOutput("to_rsp_valid", bus.rsp_valid, 4'b0100);
        checkOutput("to_rsp_slverr", bus.rsp_slverr, 1'b1);
        checkOutput("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("to_idle_psel", bus.psel, 1'b0);

        // Reset during ACCESS of a src0 write; pointer is 3 before the grant, 1 after.
        nextCycle();
        bus.prdata = 32'h0;
        applyStimulus(0, 1'b1, 32'h44, 1'b1, 32'h11112222, 4'hF, 3'd1);
        #1;
        checkOutput("rst2_req_ready", bus.req_ready, 4'b0001);
        nextCycle();
        bus.req_valid[0] = 1'b0;
        nextCycle();
        #1;
        checkOutput("rst2_in_access", bus.penable, 1'b1);
        #1;
        presetn = 1'b0;
        #1;
        checkOutput("rst2_psel", bus.psel, 1'b0);
        checkOutput("rst2_penable", bus.penable, 1'b0);
        checkOutput("rst2_paddr", bus.paddr, 32'h0);
        checkOutput("rst2_pwdata", bus.pwdata, 32'h0);
        for (int i = 0; i < NUM_REQ; i++)
            applyStimulus(i, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i), 4'hF, 3'd0);
        #1;
        checkOutput("rst2_ready_gated", bus.req_ready, 4'b0000);
        nextCycle();
        #1;
        checkOutput("rst2_no_rsp", bus.rsp_valid, 4'b0000);

        // Round-robin with all sources pending and zero wait states.
        presetn    = 1'b1;
        bus.pready = 1'b1;
        #1;
        checkOutput("rr_first_grant", bus.req_ready, 4'b0001);
        nextCycle();
        #1;
        checkOutput("rr_setup0_paddr", bus.paddr, 32'h100);
        checkOutput("rr_setup0_psel", bus.psel, 1'b1);
        for (int k = 0; k < NUM_REQ; k++) begin
            nextCycle();
            #1;
            expOneHot = 4'(1) << ((k + 1) % NUM_REQ);
            checkOutput("rr_grant", bus.req_ready, expOneHot);
            checkOutput("rr_access_psel", bus.psel, 1'b1);
            checkOutput("rr_access_penable", bus.penable, 1'b1);
            nextCycle();
            #1;
            expOneHot = 4'(1) << k;
            checkOutput("rr_rsp_valid", bus.rsp_valid, expOneHot);
            checkOutput("rr_setup_psel", bus.psel, 1'b1);
            checkOutput("rr_setup_penable", bus.penable, 1'b0);
            checkOutput("rr_setup_paddr", bus.paddr, 32'h100 + 32'(4 * ((k + 1) % NUM_REQ)));
        end
        nextCycle();
        bus.req_valid = '0;
        #1;
        checkOutput("rr_final_no_grant", bus.req_ready, 4'b0000);
        nextCycle();
        #1;
        checkOutput("rr_final_rsp", bus.rsp_valid, 4'b0001);
        checkOutput("rr_final_idle", bus.psel, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
